// File: rtl/hdmi_reset_sequencer.sv
// hdmi_reset_sequencer: staged reset release for the HDMI pixel domain after PLL lock qualification
// Ports:
//   clk             pixel clock (PLL outclk_0), rising edge
//   rst             asynchronous active-high reset (shared with PLL rst)
//   pll_locked      PLL lock flag, asynchronous to clk
//   sw_reset_req    single-cycle software reset request, synchronous to clk
//   rst_stage0..2   active-high resets: pixel pipeline, video timing, HDMI TX/config
//   ready           high once every stage is released
//   lock_loss_count saturating count of confirmed lock losses
// Optional feature: define HDMI_RSTSEQ_LOSS_CNT_EN to build the lock-loss counter;
// otherwise lock_loss_count is tied to zero.
module hdmi_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int CNT_W              = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       rst_stage0,
    output logic       rst_stage1,
    output logic       rst_stage2,
    output logic       ready,
    output logic [7:0] lock_loss_count
);
    typedef enum logic [1:0] {WAIT_LOCK, STABLE, SEQ, RUN} state_t;
    // The WAIT_LOCK->STABLE edge already counts as the first qualified cycle,
    // so STABLE terminates one count early to release stage0 at k+1+LOCK_STABLE_CYCLES.
    localparam logic [CNT_W-1:0] STABLE_END =
        CNT_W'(LOCK_STABLE_CYCLES > 1 ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(STAGE_GAP_CYCLES - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             stage_idx;
    logic             sync0;
    logic             lock_s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0      <= 1'b0;
            lock_s     <= 1'b0;
            state      <= WAIT_LOCK;
            cnt        <= '0;
            stage_idx  <= 1'b0;
            rst_stage0 <= 1'b1;
            rst_stage1 <= 1'b1;
            rst_stage2 <= 1'b1;
            ready      <= 1'b0;
        end else begin
            sync0  <= pll_locked;
            lock_s <= sync0;
            if (state != WAIT_LOCK && (!lock_s || sw_reset_req)) begin
                state      <= WAIT_LOCK;
                cnt        <= '0;
                stage_idx  <= 1'b0;
                rst_stage0 <= 1'b1;
                rst_stage1 <= 1'b1;
                rst_stage2 <= 1'b1;
                ready      <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: if (lock_s) begin
                        cnt <= '0;
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state      <= SEQ;
                            rst_stage0 <= 1'b0;
                        end else begin
                            state <= STABLE;
                        end
                    end
                    STABLE: if (cnt == STABLE_END) begin
                        state      <= SEQ;
                        cnt        <= '0;
                        rst_stage0 <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Two gap periods are counted separately via stage_idx so cnt
                    // never needs to hold 2*STAGE_GAP_CYCLES.
                    SEQ: if (cnt == GAP_END) begin
                        cnt <= '0;
                        if (stage_idx) begin
                            rst_stage2 <= 1'b0;
                            ready      <= 1'b1;
                            state      <= RUN;
                        end else begin
                            rst_stage1 <= 1'b0;
                            stage_idx  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef HDMI_RSTSEQ_LOSS_CNT_EN
    // Only losses after qualification completed (SEQ/RUN) are counted; a
    // simultaneous software request still counts because lock_s is checked alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lock_loss_count <= '0;
        else if (!lock_s && (state == SEQ || state == RUN) && lock_loss_count != 8'hff)
            lock_loss_count <= lock_loss_count + 8'd1;
    end
`else
    assign lock_loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_hdmi_reset_sequencer.sv
// tb_hdmi_reset_sequencer: directed scoreboard bench for hdmi_reset_sequencer
module tb_hdmi_reset_sequencer;
    localparam int LSC = 8;
    localparam int GAP = 4;
    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       rst_stage0;
    logic       rst_stage1;
    logic       rst_stage2;
    logic       ready;
    logic [7:0] lock_loss_count;
    int         tests;
    int         fails;
    int         t_m;
    logic       s0_m;
    logic       ls_m;
    int         cnt_m;
    logic [11:0] exp_q[$];
    hdmi_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_GAP_CYCLES(GAP),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req),
        .rst_stage0(rst_stage0),
        .rst_stage1(rst_stage1),
        .rst_stage2(rst_stage2),
        .ready(ready),
        .lock_loss_count(lock_loss_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [11:0] outs();
        return {rst_stage0, rst_stage1, rst_stage2, ready, lock_loss_count};
    endfunction
    // Model: t_m = edges since qualification began (0 = waiting for lock);
    // stage releases are thresholds on t_m.
    task automatic step(input logic r, input logic lk, input logic sw);
        logic [7:0] e_cnt;
        @(negedge clk);
        rst = r;
        pll_locked = lk;
        sw_reset_req = sw;
        if (r) begin
            t_m = 0;
            s0_m = 1'b0;
            ls_m = 1'b0;
            cnt_m = 0;
        end else begin
            if (t_m == 0) t_m = ls_m ? 1 : 0;
            else if (!ls_m) begin
                if (t_m >= LSC && cnt_m < 255) cnt_m++;
                t_m = 0;
            end else if (sw) t_m = 0;
            else if (t_m < LSC + 2 * GAP) t_m++;
            ls_m = s0_m;
            s0_m = lk;
        end
`ifdef HDMI_RSTSEQ_LOSS_CNT_EN
        e_cnt = 8'(cnt_m);
`else
        e_cnt = 8'd0;
`endif
        exp_q.push_back({t_m < LSC, t_m < LSC + GAP, t_m < LSC + 2 * GAP, t_m >= LSC + 2 * GAP, e_cnt});
        @(posedge clk);
        #1;
        check("cycle", 32'(outs()), 32'(exp_q.pop_front()));
    endtask
    initial begin
        int e0;
        int e1;
        int e2;
        int er;
        bit s2_fell;
        logic [7:0] cnt_before;
        tests = 0;
        fails = 0;
        t_m = 0;
        s0_m = 1'b0;
        ls_m = 1'b0;
        cnt_m = 0;
        rst = 1'b1;
        pll_locked = 1'b1;
        sw_reset_req = 1'b0;
        // Power-up
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("rst_outs", 32'(outs()), 32'h00000E00);
        e0 = -1; e1 = -1; e2 = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (e0 < 0 && !rst_stage0) e0 = i;
            if (e1 < 0 && !rst_stage1) e1 = i;
            if (e2 < 0 && ready) e2 = i;
        end
        check("pu_stage0_edge", e0, 9);
        check("pu_stage1_edge", e1, 13);
        check("pu_ready_edge", e2, 17);
        check("pu_count", 32'(lock_loss_count), 0);
        // Lock loss in RUN
        er = -1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (er < 0 && rst_stage0 && rst_stage1 && rst_stage2 && !ready) er = i;
        end
        check("run_loss_edge", er, 2);
`ifdef HDMI_RSTSEQ_LOSS_CNT_EN
        check("run_loss_count", 32'(lock_loss_count), 1);
`else
        check("run_loss_count", 32'(lock_loss_count), 0);
`endif
        // Glitch during qualification, then full re-sequence
        e0 = -1; e2 = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, i != 5, 1'b0);
            if (e0 < 0 && !rst_stage0) e0 = i;
            if (e2 < 0 && ready) e2 = i;
        end
        check("glitch_stage0_edge", e0, 15);
        check("glitch_ready_edge", e2, 23);
        // Loss between stage1 and stage2 release
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        cnt_before = lock_loss_count;
        e1 = -1;
        s2_fell = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step(1'b0, i < 13, 1'b0);
            if (e1 < 0 && !rst_stage1) e1 = i;
            if (!rst_stage2) s2_fell = 1'b1;
        end
        check("seq_stage1_edge", e1, 13);
        check("seq_no_stage2", 32'(s2_fell), 0);
`ifdef HDMI_RSTSEQ_LOSS_CNT_EN
        check("seq_loss_count", 32'(lock_loss_count), 32'(cnt_before) + 1);
`else
        check("seq_loss_count", 32'(lock_loss_count), 0);
`endif
        // Saturation
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        end
`ifdef HDMI_RSTSEQ_LOSS_CNT_EN
        check("sat_count", 32'(lock_loss_count), 255);
`else
        check("sat_count", 32'(lock_loss_count), 0);
`endif
        // Software reset in RUN
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        cnt_before = lock_loss_count;
        step(1'b0, 1'b1, 1'b1);
        check("sw_run_outs", 32'(outs()), 32'({4'hE, cnt_before}));
        e2 = -1;
        for (int i = 1; i < 22; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (e2 < 0 && ready) e2 = i;
        end
        check("sw_rerelease_edge", e2, 16);
        // Software request coinciding with lock loss seen by the FSM
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("sw_loss_resets", 32'(outs() >> 8), 32'hE);
        // Software request while waiting for lock
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        // Async reset in the middle of SEQ
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        check("pre_async_in_seq", 32'(rst_stage0), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", 32'(outs()), 32'h00000E00);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        check("post_async_ready", 32'(ready), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
